// File: rtl/ntsc_timing_gen.sv
// 4fsc NTSC raster sequencer: H/V counters, SYNC/BLANK/BURST/ACTIVE flags and XR phase reset.
// Optional interlace (263-line odd field with half-line vsync offset) under NTSC_TG_INTERLACE_EN.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | raster stopped, all outputs at reset values
// ST_RUN  | counters advance on every CK_EE_i, flags decoded
module ntsc_timing_gen #(
  parameter int H_TOTAL   = 910,
  parameter int H_SYNC_W  = 67,
  parameter int BURST_ST  = 76,
  parameter int BURST_W   = 36,
  parameter int H_ACT_ST  = 160,
  parameter int H_ACT_W   = 720,
  parameter int V_TOTAL   = 262,
  parameter int V_SYNC_ST = 3,
  parameter int V_SYNC_W  = 3,
  parameter int V_ACT_ST  = 20,
  parameter int V_ACT_W   = 240
) (
  input  logic       CK_i,
  input  logic       ARST_i,
  input  logic       CK_EE_i,
  input  logic       EN_i,
  output logic [9:0] HCNT_o,
  output logic [8:0] VCNT_o,
  output logic       SYNC_o,
  output logic       BLANK_o,
  output logic       BURST_o,
  output logic       ACTIVE_o,
  output logic       HSTART_o,
  output logic       VSTART_o,
  output logic       XR_o,
  output logic       FIELD_o
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_HALF    = 10'(H_TOTAL / 2);
  localparam logic [9:0] H_SW      = 10'(H_SYNC_W);
  localparam logic [9:0] SERR1_END = 10'(H_TOTAL / 2 - H_SYNC_W);
  localparam logic [9:0] SERR2_END = 10'(H_TOTAL - H_SYNC_W);
  localparam logic [9:0] BU_ST     = 10'(BURST_ST);
  localparam logic [9:0] BU_END    = 10'(BURST_ST + BURST_W);
  localparam logic [9:0] HA_ST     = 10'(H_ACT_ST);
  localparam logic [9:0] HA_END    = 10'(H_ACT_ST + H_ACT_W);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] VS_ST     = 9'(V_SYNC_ST);
  localparam logic [8:0] VS_END    = 9'(V_SYNC_ST + V_SYNC_W);
  localparam logic [8:0] VA_ST     = 9'(V_ACT_ST);
  localparam logic [8:0] VA_END    = 9'(V_ACT_ST + V_ACT_W);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  state_t state;

  logic [9:0] h_nxt;
  logic [8:0] v_nxt;
  logic [8:0] v_last;
  logic       field_nxt;
  logic       vs_win;
  logic       serr_low;
  logic       sync_d;
  logic       burst_d;
  logic       active_d;

  // In IDLE the next counts are zero, which is exactly the first RUN sample.
  always_comb begin
    h_nxt     = '0;
    v_nxt     = '0;
    field_nxt = 1'b0;
`ifdef NTSC_TG_INTERLACE_EN
    v_last    = FIELD_o ? 9'(V_TOTAL) : V_LAST;
`else
    v_last    = V_LAST;
`endif
    if (state == ST_RUN) begin
      field_nxt = FIELD_o;
      v_nxt     = VCNT_o;
      if (HCNT_o == H_LAST) begin
        if (VCNT_o == v_last) begin
          v_nxt = '0;
`ifdef NTSC_TG_INTERLACE_EN
          field_nxt = ~FIELD_o;
`else
          field_nxt = 1'b0;
`endif
        end else begin
          v_nxt = VCNT_o + 9'd1;
        end
      end else begin
        h_nxt = HCNT_o + 10'd1;
      end
    end
  end

  always_comb begin
`ifdef NTSC_TG_INTERLACE_EN
    // Odd-field vsync window is shifted by half a line.
    if (field_nxt)
      vs_win = (v_nxt == VS_ST && h_nxt >= H_HALF) || (v_nxt > VS_ST && v_nxt < VS_END) ||
               (v_nxt == VS_END && h_nxt < H_HALF);
    else
      vs_win = (v_nxt >= VS_ST) && (v_nxt < VS_END);
`else
    vs_win = (v_nxt >= VS_ST) && (v_nxt < VS_END);
`endif
    serr_low = (h_nxt < SERR1_END) || (h_nxt >= H_HALF && h_nxt < SERR2_END);
    sync_d   = vs_win ? ~serr_low : ~(h_nxt < H_SW);
    burst_d  = ~vs_win && (h_nxt >= BU_ST) && (h_nxt < BU_END);
    active_d = (h_nxt >= HA_ST) && (h_nxt < HA_END) && (v_nxt >= VA_ST) && (v_nxt < VA_END);
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state    <= ST_IDLE;
      HCNT_o   <= '0;
      VCNT_o   <= '0;
      SYNC_o   <= 1'b1;
      BLANK_o  <= 1'b1;
      BURST_o  <= 1'b0;
      ACTIVE_o <= 1'b0;
      HSTART_o <= 1'b0;
      VSTART_o <= 1'b0;
      XR_o     <= 1'b0;
      FIELD_o  <= 1'b0;
    end else if (CK_EE_i) begin
      if (EN_i) begin
        state    <= ST_RUN;
        HCNT_o   <= h_nxt;
        VCNT_o   <= v_nxt;
        SYNC_o   <= sync_d;
        BLANK_o  <= ~active_d;
        BURST_o  <= burst_d;
        ACTIVE_o <= active_d;
        HSTART_o <= (h_nxt == 10'd0);
        VSTART_o <= (h_nxt == 10'd0) && (v_nxt == 9'd0);
        XR_o     <= 1'b1;
        FIELD_o  <= field_nxt;
      end else begin
        state    <= ST_IDLE;
        HCNT_o   <= '0;
        VCNT_o   <= '0;
        SYNC_o   <= 1'b1;
        BLANK_o  <= 1'b1;
        BURST_o  <= 1'b0;
        ACTIVE_o <= 1'b0;
        HSTART_o <= 1'b0;
        VSTART_o <= 1'b0;
        XR_o     <= 1'b0;
        FIELD_o  <= 1'b0;
      end
    end
  end

endmodule
